// File: rtl/md_pkg.sv
// Shared particle-data definitions for the MD pipeline stages.
// A particle word is {valid, z, y, x}, with each lane a signed 32-bit value.
package md_pkg;
    localparam int WORD_W     = 32;
    localparam int PARTICLE_W = 97;
    localparam int VALID_BIT  = 96;
    localparam int LANES_W    = 3 * WORD_W;

    typedef struct packed {
        logic                     valid;
        logic signed [WORD_W-1:0] z;
        logic signed [WORD_W-1:0] y;
        logic signed [WORD_W-1:0] x;
    } particle_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Lane k of a packed {z,y,x} vector: k=0 is x, k=2 is z.
    function automatic logic signed [WORD_W-1:0] lane(input logic [LANES_W-1:0] vec, input int k);
        return vec[k*WORD_W +: WORD_W];
    endfunction
endpackage

// File: rtl/vec3_shift_add.sv
// Three-lane signed v + (f >>> SH), two's-complement wrap, purely combinational.
module vec3_shift_add
    import md_pkg::*;
#(
    parameter int SH = 4
) (
    input  logic [LANES_W-1:0] v,
    input  logic [LANES_W-1:0] f,
    output logic [LANES_W-1:0] sum
);
    for (genvar k = 0; k < 3; k++) begin : g_lane
        assign sum[k*WORD_W +: WORD_W] = lane(v, k) + (lane(f, k) >>> SH);
    end
endmodule

// File: rtl/velocity_updater.sv
// Streams one cell's particle list, writes v + (f >>> DT_SHIFT) into the opposite
// velocity bank and clears each consumed force entry.
module velocity_updater
    import md_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DT_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready,
    input  logic                  double_buffer,
    output logic                  done,
    output logic [WORD_W-1:0]     count,
    output logic [WORD_W-1:0]     vaddr,
    output logic [WORD_W-1:0]     faddr,
    input  logic [PARTICLE_W-1:0] r_v_cache,
    input  logic [PARTICLE_W-1:0] r_f_cache,
    output logic [WORD_W-1:0]     v_waddr,
    output logic [PARTICLE_W-1:0] w_v_cache,
    output logic                  v_we,
    output logic [WORD_W-1:0]     f_waddr,
    output logic [PARTICLE_W-1:0] w_f_cache,
    output logic                  f_we
);
    state_t             state;
    logic               bank_sel;
    logic [WORD_W-1:0]  index;
    logic [WORD_W-1:0]  d_idx;
    logic               a_vld;
    logic               d_vld;
    logic [WORD_W-1:0]  rd_base;
    logic [WORD_W-1:0]  wr_base;
    particle_t          rv;
    particle_t          rf;
    logic [LANES_W-1:0] force_lanes;
    logic [LANES_W-1:0] new_v;
    logic               live;
    logic               take;
    logic               term;

    assign rd_base   = bank_sel ? WORD_W'(DEPTH) : '0;
    assign wr_base   = bank_sel ? '0 : WORD_W'(DEPTH);
    assign w_f_cache = '0;

    assign rv          = r_v_cache;
    assign rf          = r_f_cache;
    assign force_lanes = rf.valid ? {rf.z, rf.y, rf.x} : '0;

    // a_vld marks an address on the bus; d_vld marks its data arriving one cycle later.
    assign live = (state == S_STREAM) || (state == S_DRAIN);
    assign take = live && d_vld && rv.valid;
    assign term = live && d_vld && !rv.valid;

    vec3_shift_add #(.SH(DT_SHIFT)) u_shift_add (
        .v   ({rv.z, rv.y, rv.x}),
        .f   (force_lanes),
        .sum (new_v)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bank_sel  <= 1'b0;
            index     <= '0;
            d_idx     <= '0;
            a_vld     <= 1'b0;
            d_vld     <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            vaddr     <= '0;
            faddr     <= '0;
            v_waddr   <= '0;
            w_v_cache <= '0;
            v_we      <= 1'b0;
            f_waddr   <= '0;
            f_we      <= 1'b0;
        end else begin
            v_we  <= 1'b0;
            f_we  <= 1'b0;
            d_vld <= a_vld;
            d_idx <= faddr;

            if (take) begin
                v_we      <= 1'b1;
                f_we      <= 1'b1;
                w_v_cache <= {1'b1, new_v};
                v_waddr   <= wr_base + d_idx;
                f_waddr   <= d_idx;
                count     <= count + 32'd1;
            end

            case (state)
                S_IDLE: begin
                    a_vld <= 1'b0;
                    d_vld <= 1'b0;
                    if (ready) begin
                        state    <= S_STREAM;
                        done     <= 1'b0;
                        count    <= '0;
                        index    <= '0;
                        bank_sel <= double_buffer;
                    end
                end
                S_STREAM: begin
                    // An invalid entry ends the list; reads still in flight are dropped.
                    if (term) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        a_vld <= 1'b0;
                        d_vld <= 1'b0;
                    end else begin
                        vaddr <= rd_base + index;
                        faddr <= index;
                        a_vld <= 1'b1;
                        index <= index + 32'd1;
                        if (index == WORD_W'(DEPTH - 1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    a_vld <= 1'b0;
                    if (term || (!a_vld && !d_vld)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        d_vld <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    a_vld <= 1'b0;
                    d_vld <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
